// File: rtl/dram_dq_rdfifo_lane_if.sv
// Handshake and data bundle between the DQ pad capture, the read lane
// and the DRAM controller read port.
interface dram_dq_rdfifo_lane_if #(
    parameter int DQ_W  = 4,
    parameter int PTR_W = 3,
    parameter int LAT_W = 3
);
    logic             channel_disabled;
    logic             burst_length_four;
    logic [LAT_W-1:0] rd_lat;
    logic             dqs_read;
    logic [DQ_W-1:0]  cap_pos;
    logic [DQ_W-1:0]  cap_neg;
    logic             rd_pop;
    logic             clr_err;
    logic [DQ_W-1:0]  io_dram_data_in;
    logic [DQ_W-1:0]  io_dram_data_in_hi;
    logic             rd_valid;
    logic             fifo_empty;
    logic             fifo_full;
    logic [PTR_W:0]   fifo_level;
    logic             burst_done;
    logic             overflow;
    logic             burst_err;

    modport master (
        output channel_disabled, burst_length_four, rd_lat, dqs_read,
        output cap_pos, cap_neg, rd_pop, clr_err,
        input  io_dram_data_in, io_dram_data_in_hi, rd_valid,
        input  fifo_empty, fifo_full, fifo_level,
        input  burst_done, overflow, burst_err
    );

    modport slave (
        input  channel_disabled, burst_length_four, rd_lat, dqs_read,
        input  cap_pos, cap_neg, rd_pop, clr_err,
        output io_dram_data_in, io_dram_data_in_hi, rd_valid,
        output fifo_empty, fifo_full, fifo_level,
        output burst_done, overflow, burst_err
    );
endinterface

// File: rtl/dram_dq_rdfifo_lane.sv
// DRAM DQ read-capture lane: waits the read latency, captures BL4/BL8
// DDR beat pairs into a pointer FIFO and returns them on controller pops.
module dram_dq_rdfifo_lane #(
    parameter int DQ_W  = 4,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int LAT_W = 3
) (
    input logic rclk,
    input logic arst_l,
    dram_dq_rdfifo_lane_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam logic [LAT_W-1:0] LAT_ONE = 1;

    state_t           state, state_n;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_n;
    logic [1:0]       beat_cnt, beat_cnt_n;
    logic             bl4_q, bl4_n;
    logic             done_n;
    logic             done_q;

    logic [PTR_W:0]   wptr, rptr;
    logic [2*DQ_W-1:0] mem [DEPTH];
    logic [DQ_W-1:0]  data_pos, data_neg;
    logic             valid_q;
    logic             ovf_q, berr_q;

    logic empty, full, off;
    logic push, do_push, do_pop, drop, last_beat, bad_read;

    assign off       = bus.channel_disabled;
    assign empty     = (wptr == rptr);
    assign full      = (wptr[PTR_W] != rptr[PTR_W]) &&
                       (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign do_pop    = bus.rd_pop && !empty && !off;
    assign push      = (state == S_CAPTURE) && !off;
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;
    assign last_beat = (beat_cnt == (bl4_q ? 2'd1 : 2'd3));
    assign bad_read  = bus.dqs_read && (state != S_IDLE) && !off;

    // Burst sequencing: latency countdown, then one capture per cycle.
    always_comb begin
        state_n    = state;
        lat_cnt_n  = lat_cnt;
        beat_cnt_n = beat_cnt;
        bl4_n      = bl4_q;
        done_n     = 1'b0;
        if (off) begin
            state_n    = S_IDLE;
            lat_cnt_n  = '0;
            beat_cnt_n = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.dqs_read) begin
                        bl4_n      = bus.burst_length_four;
                        lat_cnt_n  = bus.rd_lat;
                        beat_cnt_n = '0;
                        state_n    = (bus.rd_lat != '0) ? S_WAIT : S_CAPTURE;
                    end
                end
                S_WAIT: begin
                    lat_cnt_n = lat_cnt - LAT_ONE;
                    if (lat_cnt == LAT_ONE) begin
                        state_n = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    beat_cnt_n = beat_cnt + 2'd1;
                    if (last_beat) begin
                        state_n    = S_IDLE;
                        beat_cnt_n = '0;
                        done_n     = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Burst sequencer state.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state    <= S_IDLE;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            bl4_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            lat_cnt  <= lat_cnt_n;
            beat_cnt <= beat_cnt_n;
            bl4_q    <= bl4_n;
            done_q   <= done_n;
        end
    end

    // FIFO pointers; the extra MSB separates full from empty.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wptr <= '0;
            rptr <= '0;
        end else if (off) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Beat-pair storage, neg beat in the upper half.
    always_ff @(posedge rclk) begin
        if (do_push) begin
            mem[wptr[PTR_W-1:0]] <= {bus.cap_neg, bus.cap_pos};
        end
    end

    // Registered read port; data holds when nothing is popped.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            data_pos <= '0;
            data_neg <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= do_pop;
            if (do_pop) begin
                {data_neg, data_pos} <= mem[rptr[PTR_W-1:0]];
            end
        end
    end

    // Sticky error flags; a new error beats a same-cycle clear.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ovf_q  <= 1'b0;
            berr_q <= 1'b0;
        end else begin
            ovf_q  <= drop     || (ovf_q  && !bus.clr_err);
            berr_q <= bad_read || (berr_q && !bus.clr_err);
        end
    end

    assign bus.io_dram_data_in    = data_pos;
    assign bus.io_dram_data_in_hi = data_neg;
    assign bus.rd_valid           = valid_q;
    assign bus.fifo_empty         = empty;
    assign bus.fifo_full          = full;
    assign bus.fifo_level         = wptr - rptr;
    assign bus.burst_done         = done_q;
    assign bus.overflow           = ovf_q;
    assign bus.burst_err          = berr_q;
endmodule

// File: tb/tb_dram_dq_rdfifo_lane.sv
// Scoreboard bench for the DQ read-capture lane: directed bursts push
// expected beat pairs, a negedge monitor checks every rd_valid output.
module tb_dram_dq_rdfifo_lane;
    localparam int DQ_W  = 4;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int LAT_W = 3;

    logic rclk = 1'b0;
    logic arst_l = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   mlevel = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 rclk = ~rclk;

    dram_dq_rdfifo_lane_if #(.DQ_W(DQ_W), .PTR_W(PTR_W), .LAT_W(LAT_W)) bus ();

    dram_dq_rdfifo_lane #(
        .DQ_W(DQ_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .LAT_W(LAT_W)
    ) dut (
        .rclk(rclk),
        .arst_l(arst_l),
        .bus(bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Issue dqs_read, wait the latency, drive the beats; optionally pop
    // on every capture cycle. Expected pairs are {pos,neg}.
    task automatic burst(input bit bl4, input int lat,
                         input logic [15:0] pv, input logic [15:0] nv,
                         input bit popping);
        int  beats;
        bit  pop_now;
        beats = bl4 ? 2 : 4;
        bus.burst_length_four = bl4;
        bus.rd_lat = LAT_W'(lat);
        bus.dqs_read = 1'b1;
        tick();
        bus.dqs_read = 1'b0;
        bus.burst_length_four = ~bl4;
        repeat (lat) tick();
        check("no_early_push", int'(bus.fifo_level), mlevel);
        for (int i = 0; i < beats; i++) begin
            bus.cap_pos = pv[4*i +: 4];
            bus.cap_neg = nv[4*i +: 4];
            pop_now = popping && (mlevel > 0);
            bus.rd_pop = pop_now;
            if (mlevel < DEPTH || pop_now) begin
                exp_q.push_back({pv[4*i +: 4], nv[4*i +: 4]});
                mlevel++;
            end
            if (pop_now) mlevel--;
            tick();
        end
        bus.rd_pop = 1'b0;
        check("burst_done", int'(bus.burst_done), 1);
    endtask

    task automatic pop();
        bus.rd_pop = 1'b1;
        tick();
        bus.rd_pop = 1'b0;
        mlevel--;
        check("rd_valid", int'(bus.rd_valid), 1);
    endtask

    // Monitor: every presented entry must match the scoreboard head.
    initial begin
        forever begin
            @(negedge rclk);
            if (bus.rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_unexpected: got %h want none",
                             {bus.io_dram_data_in, bus.io_dram_data_in_hi});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rd_data",
                          int'({bus.io_dram_data_in, bus.io_dram_data_in_hi}),
                          int'(mon_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.channel_disabled = 1'b0;
        bus.burst_length_four = 1'b0;
        bus.rd_lat = '0;
        bus.dqs_read = 1'b0;
        bus.cap_pos = '0;
        bus.cap_neg = '0;
        bus.rd_pop = 1'b0;
        bus.clr_err = 1'b0;

        // Reset state
        #12;
        check("rst_empty", int'(bus.fifo_empty), 1);
        check("rst_level", int'(bus.fifo_level), 0);
        check("rst_full", int'(bus.fifo_full), 0);
        check("rst_valid", int'(bus.rd_valid), 0);
        check("rst_data", int'({bus.io_dram_data_in, bus.io_dram_data_in_hi}), 0);
        check("rst_flags", int'({bus.overflow, bus.burst_err, bus.burst_done}), 0);
        tick();
        arst_l = 1'b1;
        tick();

        // BL4, latency 0
        burst(1'b1, 0, 16'h0021, 16'h00A9, 1'b0);
        check("bl4_level", int'(bus.fifo_level), 2);
        tick();
        check("done_pulse", int'(bus.burst_done), 0);
        pop();
        pop();
        tick();
        check("valid_drop", int'(bus.rd_valid), 0);
        check("drain_empty", int'(bus.fifo_empty), 1);
        bus.rd_pop = 1'b1;
        tick();
        bus.rd_pop = 1'b0;
        check("pop_empty_valid", int'(bus.rd_valid), 0);
        check("pop_empty_hold", int'(bus.io_dram_data_in), 2);

        // BL8, latency 3
        burst(1'b0, 3, 16'h6543, 16'hEDCB, 1'b0);
        check("bl8_level", int'(bus.fifo_level), 4);
        repeat (4) pop();
        tick();

        // Overflow: three BL8 bursts, pointers wrap past DEPTH
        burst(1'b0, 0, 16'h4321, 16'h8765, 1'b0);
        burst(1'b0, 0, 16'hCBA9, 16'h0FED, 1'b0);
        check("fill_no_ovf", int'(bus.overflow), 0);
        check("fill_full", int'(bus.fifo_full), 1);
        burst(1'b0, 0, 16'h1111, 16'h2222, 1'b0);
        check("ovf_level", int'(bus.fifo_level), 8);
        check("ovf_full", int'(bus.fifo_full), 1);
        check("ovf_flag", int'(bus.overflow), 1);
        check("ovf_no_berr", int'(bus.burst_err), 0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("ovf_clear", int'(bus.overflow), 0);

        // Full FIFO, pop during every capture push
        burst(1'b1, 0, 16'h0035, 16'h0046, 1'b1);
        check("fullpp_level", int'(bus.fifo_level), 8);
        check("fullpp_no_ovf", int'(bus.overflow), 0);
        repeat (8) pop();
        tick();
        check("wrap_empty", int'(bus.fifo_empty), 1);

        // dqs_read during WAIT and on the last capture cycle
        bus.burst_length_four = 1'b1;
        bus.rd_lat = 3'd3;
        bus.dqs_read = 1'b1;
        tick();
        bus.dqs_read = 1'b0;
        tick();
        bus.dqs_read = 1'b1;
        tick();
        bus.dqs_read = 1'b0;
        tick();
        bus.cap_pos = 4'h7;
        bus.cap_neg = 4'h1;
        exp_q.push_back(8'h71);
        tick();
        bus.cap_pos = 4'h8;
        bus.cap_neg = 4'h2;
        bus.dqs_read = 1'b1;
        exp_q.push_back(8'h82);
        tick();
        bus.dqs_read = 1'b0;
        mlevel = 2;
        check("berr_set", int'(bus.burst_err), 1);
        repeat (6) tick();
        check("single_burst", int'(bus.fifo_level), 2);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("berr_clear", int'(bus.burst_err), 0);
        pop();
        pop();
        tick();

        // channel_disabled mid-capture
        bus.burst_length_four = 1'b0;
        bus.rd_lat = '0;
        bus.dqs_read = 1'b1;
        tick();
        bus.dqs_read = 1'b0;
        bus.cap_pos = 4'h3;
        tick();
        tick();
        check("dis_pre_level", int'(bus.fifo_level), 2);
        bus.channel_disabled = 1'b1;
        tick();
        bus.channel_disabled = 1'b0;
        check("dis_empty", int'(bus.fifo_empty), 1);
        check("dis_level", int'(bus.fifo_level), 0);
        check("dis_hold", int'({bus.io_dram_data_in, bus.io_dram_data_in_hi}), 8'h82);
        tick();
        check("dis_no_done", int'(bus.burst_done), 0);
        tick();
        check("dis_idle", int'(bus.fifo_level), 0);
        burst(1'b1, 1, 16'h00DC, 16'h0054, 1'b0);
        check("post_dis_level", int'(bus.fifo_level), 2);
        pop();
        tick();

        // Asynchronous reset mid-burst with data held
        bus.burst_length_four = 1'b0;
        bus.dqs_read = 1'b1;
        tick();
        bus.dqs_read = 1'b0;
        bus.cap_pos = 4'h9;
        tick();
        tick();
        #2;
        arst_l = 1'b0;
        #1;
        check("arst_empty", int'(bus.fifo_empty), 1);
        check("arst_level", int'(bus.fifo_level), 0);
        check("arst_data", int'({bus.io_dram_data_in, bus.io_dram_data_in_hi}), 0);
        check("arst_flags", int'({bus.rd_valid, bus.burst_done, bus.fifo_full}), 0);
        exp_q.delete();
        mlevel = 0;
        tick();
        arst_l = 1'b1;
        repeat (3) tick();
        check("arst_idle", int'(bus.fifo_level), 0);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
